// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and memory-pin bundle for mem_access_ctrl.
// The slave modport is the controller view; the master modport is the environment view.
interface mem_access_ctrl_if #(
    parameter int ADR_W  = 3,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADR_W-1:0]  req_adr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [ADR_W-1:0]  rsp_adr;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_read;
    logic              mem_write;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req_valid, req_write, req_adr, req_data, rsp_ready, mem_q,
        output req_ready, rsp_valid, rsp_write, rsp_adr, rsp_data,
               mem_read, mem_write, mem_adr, mem_data
    );

    modport master (
        output req_valid, req_write, req_adr, req_data, rsp_ready, mem_q,
        input  req_ready, rsp_valid, rsp_write, rsp_adr, rsp_data,
               mem_read, mem_write, mem_adr, mem_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request sequencer for the 8x8 latch memory: shapes exclusive
// read/write strobes, samples the read word in the HOLD cycle, returns it with backpressure.
module mem_access_ctrl #(
    parameter int ADR_W         = 3,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, RESP} state_e;

    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              rsp_write_q, rsp_write_d;
    logic [ADR_W-1:0]  rsp_adr_q, rsp_adr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_data_d  = mem_data_q;
        rsp_write_d = rsp_write_q;
        rsp_adr_d   = rsp_adr_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_write_d  = bus.req_write;
                    mem_adr_d   = bus.req_adr;
                    mem_data_d  = bus.req_data;
                    mem_write_d = bus.req_write;
                    mem_read_d  = !bus.req_write;
                    cnt_d       = STROBE_LD;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q - 4'd1;
                // Strobes are registered, so dropping them here ends the pulse after cnt cycles.
                if (cnt_q == 4'd1) begin
                    state_d = HOLD;
                end else begin
                    mem_write_d = op_write_q;
                    mem_read_d  = !op_write_q;
                end
            end
            HOLD: begin
                rsp_write_d = op_write_q;
                rsp_adr_d   = mem_adr_q;
                rsp_data_d  = op_write_q ? mem_data_q : bus.mem_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_adr_q   <= '0;
            mem_data_q  <= '0;
            rsp_write_q <= 1'b0;
            rsp_adr_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_adr_q   <= mem_adr_d;
            mem_data_q  <= mem_data_d;
            rsp_write_q <= rsp_write_d;
            rsp_adr_q   <= rsp_adr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_adr   = rsp_adr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_data  = mem_data_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: one controller with 1-cycle strobes against a small memory model,
// plus a second controller with 3-cycle strobes for the strobe-width case.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADR_W(3), .DATA_W(8)) b1 ();
    mem_access_ctrl_if #(.ADR_W(3), .DATA_W(8)) b2 ();

    mem_access_ctrl #(.ADR_W(3), .DATA_W(8), .STROBE_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    mem_access_ctrl #(.ADR_W(3), .DATA_W(8), .STROBE_CYCLES(3)) u2 (.clk(clk), .reset(reset), .bus(b2));

    // Memory model: the read word is only driven in the cycle after a read strobe.
    logic [7:0] mem [8];
    logic       en_q;
    always @(posedge clk) begin
        if (b1.mem_write) mem[b1.mem_adr] <= b1.mem_data;
        en_q <= b1.mem_read;
    end
    assign b1.mem_q = en_q ? mem[b1.mem_adr] : 8'h00;
    assign b2.mem_q = 8'h00;

    int         acc_q [$];
    logic [7:0] rsp_q [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b1.req_valid && b1.req_ready) acc_q.push_back(cyc);
        if (b1.rsp_valid && b1.rsp_ready) rsp_q.push_back(b1.rsp_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("excl1", 32'(b1.mem_read & b1.mem_write), 32'd0);
            chk("excl2", 32'(b2.mem_read & b2.mem_write), 32'd0);
        end
    end

    task automatic wait_acc(input int n, input string tag);
        int k = 0;
        while (acc_q.size() < n && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    initial begin
        logic       ow [3];
        logic [2:0] oa [3];
        logic [7:0] od [3];
        int         r0;
        int         k;
        ow = '{1'b1, 1'b0, 1'b0};
        oa = '{3'd1, 3'd1, 3'd0};
        od = '{8'h02, 8'h00, 8'h00};
        foreach (mem[i]) mem[i] = 8'h00;

        // Reset held two cycles with a request pending
        reset = 1'b1;
        b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_adr = 3'd5; b1.req_data = 8'hFF;
        b1.rsp_ready = 1'b1;
        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_adr = 3'd0; b2.req_data = 8'h00;
        b2.rsp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(b1.req_ready), 32'd0);
            chk("rst_mem_write", 32'(b1.mem_write), 32'd0);
            chk("rst_mem_read", 32'(b1.mem_read), 32'd0);
            chk("rst_mem_adr", 32'(b1.mem_adr), 32'd0);
            chk("rst_mem_data", 32'(b1.mem_data), 32'h00);
            chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(b1.rsp_data), 32'h00);
            chk("rst_rsp_adr", 32'(b1.rsp_adr), 32'd0);
            chk("rst_rsp_write", 32'(b1.rsp_write), 32'd0);
        end
        reset = 1'b0; b1.req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(b1.req_ready), 32'd1);
        chk("post_rst_wr", 32'(b1.mem_write), 32'd0);

        // Write 0x01 @0
        b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_adr = 3'd0; b1.req_data = 8'h01;
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("w0_mem_write", 32'(b1.mem_write), 32'd1);
        chk("w0_mem_read", 32'(b1.mem_read), 32'd0);
        chk("w0_mem_data", 32'(b1.mem_data), 32'h01);
        chk("w0_mem_adr", 32'(b1.mem_adr), 32'd0);
        chk("w0_req_ready", 32'(b1.req_ready), 32'd0);
        @(negedge clk);
        chk("w0_hold_wr", 32'(b1.mem_write), 32'd0);
        chk("w0_hold_rv", 32'(b1.rsp_valid), 32'd0);
        @(negedge clk);
        chk("w0_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        chk("w0_rsp_data", 32'(b1.rsp_data), 32'h01);
        chk("w0_rsp_write", 32'(b1.rsp_write), 32'd1);
        @(negedge clk);
        chk("w0_idle_ready", 32'(b1.req_ready), 32'd1);
        chk("w0_idle_rv", 32'(b1.rsp_valid), 32'd0);

        // Read @0
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_adr = 3'd0;
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("r0_mem_read", 32'(b1.mem_read), 32'd1);
        chk("r0_mem_write", 32'(b1.mem_write), 32'd0);
        @(negedge clk);
        chk("r0_hold_rd", 32'(b1.mem_read), 32'd0);
        chk("r0_hold_rv", 32'(b1.rsp_valid), 32'd0);
        @(negedge clk);
        chk("r0_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        chk("r0_rsp_data", 32'(b1.rsp_data), 32'h01);
        chk("r0_rsp_write", 32'(b1.rsp_write), 32'd0);
        chk("r0_rsp_adr", 32'(b1.rsp_adr), 32'd0);
        @(negedge clk);

        // Streaming: write 0x02 @1, read @1, read @0 with req_valid held
        acc_q.delete(); rsp_q.delete();
        for (int i = 0; i < 3; i++) begin
            b1.req_valid = 1'b1; b1.req_write = ow[i]; b1.req_adr = oa[i]; b1.req_data = od[i];
            wait_acc(i + 1, "str_accept");
        end
        b1.req_valid = 1'b0;
        k = 0;
        while (rsp_q.size() < 3 && k < 20) begin @(negedge clk); k++; end
        chk("str_rsp_count", 32'(rsp_q.size()), 32'd3);
        if (rsp_q.size() == 3 && acc_q.size() == 3) begin
            chk("str_rsp0", 32'(rsp_q[0]), 32'h02);
            chk("str_rsp1", 32'(rsp_q[1]), 32'h02);
            chk("str_rsp2", 32'(rsp_q[2]), 32'h01);
            chk("str_gap01", 32'(acc_q[1] - acc_q[0]), 32'd4);
            chk("str_gap12", 32'(acc_q[2] - acc_q[1]), 32'd4);
        end
        @(negedge clk);

        // Backpressure: read @1 with rsp_ready low for 5 RESP cycles
        r0 = rsp_q.size();
        b1.rsp_ready = 1'b0;
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_adr = 3'd1;
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("bp_mem_read", 32'(b1.mem_read), 32'd1);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(b1.rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(b1.rsp_data), 32'h02);
            chk("bp_req_ready", 32'(b1.req_ready), 32'd0);
            chk("bp_strobes", 32'({b1.mem_read, b1.mem_write}), 32'd0);
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_rv", 32'(b1.rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(b1.req_ready), 32'd1);
        chk("bp_one_rsp", 32'(rsp_q.size()), 32'(r0 + 1));

        // Reset during ISSUE of a write
        b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_adr = 3'd3; b1.req_data = 8'h77;
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("mr_issue_wr", 32'(b1.mem_write), 32'd1);
        r0 = rsp_q.size();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_wr", 32'(b1.mem_write), 32'd0);
        chk("mr_rd", 32'(b1.mem_read), 32'd0);
        chk("mr_rv", 32'(b1.rsp_valid), 32'd0);
        chk("mr_adr", 32'(b1.mem_adr), 32'd0);
        chk("mr_ready_in_rst", 32'(b1.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_idle", 32'(b1.req_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("mr_no_rsp", 32'(rsp_q.size()), 32'(r0));

        // Strobe width 3: write 0x5A @7 on the second controller
        b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_adr = 3'd7; b2.req_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b2.req_valid = 1'b0;
            chk("s3_wr_high", 32'(b2.mem_write), 32'd1);
            chk("s3_adr", 32'(b2.mem_adr), 32'd7);
            chk("s3_data", 32'(b2.mem_data), 32'h5A);
            chk("s3_rv_low", 32'(b2.rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("s3_hold_wr", 32'(b2.mem_write), 32'd0);
        chk("s3_hold_rv", 32'(b2.rsp_valid), 32'd0);
        chk("s3_hold_adr", 32'(b2.mem_adr), 32'd7);
        @(negedge clk);
        chk("s3_rsp_valid", 32'(b2.rsp_valid), 32'd1);
        chk("s3_rsp_data", 32'(b2.rsp_data), 32'h5A);
        chk("s3_rsp_adr", 32'(b2.rsp_adr), 32'd7);
        chk("s3_rsp_write", 32'(b2.rsp_write), 32'd1);
        chk("s3_resp_adr", 32'(b2.mem_adr), 32'd7);
        chk("s3_resp_data", 32'(b2.mem_data), 32'h5A);
        @(negedge clk);
        chk("s3_idle", 32'(b2.req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
